// File: rtl/adder_pkg.sv
// adder_pkg: chunk sizing, saturation constants and mode encoding shared by the pipelined adder
package adder_pkg;
  localparam int MAX_W = 1024;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  function automatic int chunk_width(input int w, input int s);
    return w / s;
  endfunction
  function automatic logic [MAX_W-1:0] sat_min(input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    r[w-1] = 1'b1;
    return r;
  endfunction
  function automatic logic [MAX_W-1:0] sat_max(input int w);
    return sat_min(w) - 1'b1;
  endfunction
endpackage

// File: rtl/adder_stage.sv
// adder_stage: one CHUNK-bit slice of the pipelined adder with its stage register and load logic
// PIPELINED_ADDER_SAT_EN clamps the result in the last stage on signed overflow
module adder_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int IDX = 0,
  parameter bit LAST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vin,
  input  logic             dn_load,
  output logic             load,
  output logic             vout,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] s_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] s_q,
  output logic             c_q,
  output logic             o_q
);
  logic [CHUNK:0] part;
  logic [WIDTH-1:0] s_nx, s_d;
  logic o_nx;
  assign load = !vout || dn_load;
  always_comb begin
    part = {1'b0, a_in[IDX*CHUNK +: CHUNK]} + {1'b0, b_in[IDX*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c_in};
    s_nx = s_in;
    s_nx[IDX*CHUNK +: CHUNK] = part[CHUNK-1:0];
    o_nx = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (s_nx[WIDTH-1] != a_in[WIDTH-1]);
`ifdef PIPELINED_ADDER_SAT_EN
    s_d = (LAST && o_nx) ? (a_in[WIDTH-1] ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH))) : s_nx;
`else
    s_d = s_nx;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vout <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      s_q  <= '0;
      c_q  <= 1'b0;
      o_q  <= 1'b0;
    end else if (load) begin
      vout <= vin;
      if (vin) begin
        a_q <= a_in;
        b_q <= b_in;
        s_q <= s_d;
        c_q <= part[CHUNK];
        o_q <= o_nx;
      end
    end
  end
endmodule

// File: rtl/pipelined_nbit_adder.sv
// pipelined_nbit_adder: valid/ready pipelined adder/subtractor resolving one chunk per stage
// PIPELINED_ADDER_SAT_EN enables signed saturation of the result
module pipelined_nbit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  logic [WIDTH-1:0] ap [STAGES+1];
  logic [WIDTH-1:0] bp [STAGES+1];
  logic [WIDTH-1:0] sp [STAGES+1];
  logic cp [STAGES+1];
  logic vp [STAGES+1];
  logic ld [STAGES+1];
  logic op [STAGES];
  if (WIDTH % STAGES != 0) begin : g_bad_split
    $error("WIDTH must be divisible by STAGES");
  end
  assign ap[0] = a;
  assign bp[0] = (sub == MODE_SUB) ? ~b : b;
  assign sp[0] = '0;
  assign cp[0] = (sub == MODE_SUB) ? 1'b1 : cin;
  assign vp[0] = in_valid;
  assign ld[STAGES] = out_ready;
  assign in_ready = ld[0];
  assign out_valid = vp[STAGES];
  assign sum = sp[STAGES];
  assign cout = cp[STAGES];
  assign overflow = op[STAGES-1];
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(
      .WIDTH(WIDTH),
      .CHUNK(CHUNK),
      .IDX(k),
      .LAST(k == STAGES - 1)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .vin(vp[k]),
      .dn_load(ld[k+1]),
      .load(ld[k]),
      .vout(vp[k+1]),
      .a_in(ap[k]),
      .b_in(bp[k]),
      .s_in(sp[k]),
      .c_in(cp[k]),
      .a_q(ap[k+1]),
      .b_q(bp[k+1]),
      .s_q(sp[k+1]),
      .c_q(cp[k+1]),
      .o_q(op[k])
    );
  end
endmodule

// File: tb/tb_pipelined_nbit_adder.sv
// tb_pipelined_nbit_adder: randomized and directed checks of the pipelined adder against a signed-arithmetic model
module tb_pipelined_nbit_adder;
  localparam int W = 32;
  localparam int S = 4;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));
  typedef struct {
    logic [W-1:0] s;
    logic c;
    logic o;
    int e;
  } beat_t;
  logic clk = 0, rst = 1, in_valid = 0, cin = 0, sub = 0, out_ready = 1;
  logic in_ready, out_valid, cout, overflow;
  logic [W-1:0] a = '0, b = '0, sum;
  int checks = 0, errors = 0, cyc = 0;
  bit chk_lat = 0, stalled = 0;
  logic [W-1:0] hold_s;
  logic hold_c, hold_o;
  beat_t q[$];
  pipelined_nbit_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic beat_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic su, input int e);
    beat_t r;
    longint sx, sy, res, ux, uy;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ux = longint'(x);
    uy = longint'(y);
    res = su ? sx - sy : sx + sy + longint'(ci);
    r.c = su ? (ux >= uy) : ((ux + uy + longint'(ci)) >= (longint'(1) << W));
    r.o = (res > SMAX) || (res < SMIN);
    r.s = W'(res);
`ifdef PIPELINED_ADDER_SAT_EN
    if (r.o) r.s = (res > 0) ? W'(SMAX) : W'(SMIN);
`endif
    r.e = e;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    beat_t e;
    @(negedge clk);
    chk("in_ready", in_ready, !(q.size() == S && !out_ready));
    if (stalled) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_sum", sum, hold_s);
      chk("hold_cout", cout, hold_c);
      chk("hold_ovf", overflow, hold_o);
    end
    if (q.size() == 0) chk("idle_valid", out_valid, 1'b0);
    else if (out_valid && out_ready) begin
      e = q.pop_front();
      chk("sum", sum, e.s);
      chk("cout", cout, e.c);
      chk("overflow", overflow, e.o);
      if (chk_lat) chk("latency", cyc + 1 - e.e, S);
    end
    stalled = out_valid && !out_ready;
    hold_s = sum;
    hold_c = cout;
    hold_o = overflow;
    if (in_valid && in_ready) q.push_back(model(a, b, cin, sub, cyc + 1));
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic beat(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic su);
    a = x;
    b = y;
    cin = ci;
    sub = su;
    in_valid = 1;
    step();
    in_valid = 0;
  endtask
  task automatic drain();
    out_ready = 1;
    in_valid = 0;
    for (int i = 0; i < 40 && q.size() != 0; i++) step();
    chk("drain", q.size(), 0);
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    rst = 0;
    chk_lat = 1;
    step();
    beat(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    beat(32'h80000000, 32'h00000001, 1'b1, 1'b1);
    beat(32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0);
    beat(32'h12345678, 32'h12345678, 1'b0, 1'b1);
    drain();
    for (int i = 0; i < 20; i++) beat($urandom, $urandom, 1'($urandom), 1'($urandom));
    drain();
    chk_lat = 0;
    n = 0;
    for (int i = 0; i < 500 && n < 16; i++) begin
      a = $urandom;
      b = $urandom;
      cin = 1'($urandom);
      sub = 1'($urandom);
      in_valid = ($urandom % 4) != 0;
      out_ready = 1'($urandom);
      if (in_valid && in_ready) n++;
      step();
    end
    chk("stream_beats", n, 16);
    drain();
    chk_lat = 1;
    for (int i = 0; i < 3; i++) beat($urandom, $urandom, 1'($urandom), 1'b0);
    #2;
    rst = 1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_sum", sum, '0);
    chk("arst_cout", cout, 1'b0);
    chk("arst_ovf", overflow, 1'b0);
    q.delete();
    stalled = 0;
    @(posedge clk);
    cyc++;
    #1;
    rst = 0;
    repeat (6) step();
    beat(32'd5, 32'd7, 1'b0, 1'b0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
